// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared DMA command codes, FSM states and command record
package dma_pkg;

    localparam logic [2:0] DMA_F3_MEM2PIM = 3'b000;
    localparam logic [2:0] DMA_F3_PIM2MEM = 3'b001;

    localparam int DMA_XLEN  = 32;
    localparam int DMA_CNT_W = 11;

    typedef enum logic [1:0] {
        IDLE,
        SRC,
        CAP,
        DST
    } dma_state_e;

    typedef enum logic {
        DIR_MEM2PIM,
        DIR_PIM2MEM
    } dma_dir_e;

    typedef struct packed {
        dma_dir_e               dir;
        logic [3:0]             sel;
        logic [DMA_XLEN-1:0]    maddr;
        logic [DMA_CNT_W-1:0]   cnt;
    } dma_cmd_t;

endpackage

// File: rtl/dma_ctrl_if.sv
// rtl/dma_ctrl_if.sv - data-memory arbiter port and PIM port of the DMA engine
interface dma_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int PIM_AW = 11
);
    logic              mem_req_o;
    logic              mem_gnt_i;
    logic [XLEN-1:0]   mem_addr_o;
    logic [XLEN-1:0]   mem_wr_data_o;
    logic [XLEN-1:0]   mem_rd_data_i;
    logic [3:0]        mem_size_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic [3:0]        pim_sel_o;
    logic [PIM_AW-1:0] pim_addr_o;
    logic [XLEN-1:0]   pim_wr_data_o;
    logic [XLEN-1:0]   pim_rd_data_i;
    logic              pim_read_o;
    logic              pim_write_o;

    modport master (
        output mem_req_o, mem_addr_o, mem_wr_data_o, mem_size_o, mem_read_o, mem_write_o,
        output pim_sel_o, pim_addr_o, pim_wr_data_o, pim_read_o, pim_write_o,
        input  mem_gnt_i, mem_rd_data_i, pim_rd_data_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, mem_wr_data_o, mem_size_o, mem_read_o, mem_write_o,
        input  pim_sel_o, pim_addr_o, pim_wr_data_o, pim_read_o, pim_write_o,
        output mem_gnt_i, mem_rd_data_i, pim_rd_data_i
    );

endinterface

// File: rtl/dma_ctrl.sv
// rtl/dma_ctrl.sv - word-by-word DMA between data memory and one PIM unit
module dma_ctrl
    import dma_pkg::*;
#(
    parameter int XLEN   = DMA_XLEN,
    parameter int PIM_AW = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             dma_en_i,
    input  logic [2:0]       dma_funct3_i,
    input  logic [3:0]       dma_sel_pim_i,
    input  logic [12:0]      dma_size_i,
    input  logic [XLEN-1:0]  dma_mem_addr_i,
    output logic             dma_busy_o,
    dma_ctrl_if.master       bus
);

    dma_state_e           state_q, state_d;
    dma_cmd_t             cmd_q, cmd_d;
    logic [PIM_AW-1:0]    paddr_q, paddr_d;
    logic [XLEN-1:0]      buf_q, buf_d;

    logic [DMA_CNT_W-1:0] words;
    logic                 op_ok;
    logic                 cmd_valid;
    logic                 in_src, in_dst;
    logic                 m2p;
    logic                 unused_bits;

    assign words       = dma_size_i[12:2];
    assign op_ok       = (dma_funct3_i == DMA_F3_MEM2PIM) || (dma_funct3_i == DMA_F3_PIM2MEM);
    assign cmd_valid   = dma_en_i && op_ok && (words != '0);
    assign unused_bits = ^{dma_size_i[1:0], dma_mem_addr_i[1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            paddr_q <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            paddr_q <= paddr_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        paddr_d = paddr_q;
        buf_d   = buf_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_d.dir   = (dma_funct3_i == DMA_F3_MEM2PIM) ? DIR_MEM2PIM : DIR_PIM2MEM;
                    cmd_d.sel   = dma_sel_pim_i;
                    cmd_d.maddr = {dma_mem_addr_i[XLEN-1:2], 2'b00};
                    cmd_d.cnt   = words;
                    paddr_d     = '0;
                    state_d     = SRC;
                end
            end
            SRC: begin
                // PIM reads always complete in one cycle; memory waits for grant
                if (!m2p || bus.mem_gnt_i) state_d = CAP;
            end
            CAP: begin
                buf_d   = m2p ? bus.mem_rd_data_i : bus.pim_rd_data_i;
                state_d = DST;
            end
            DST: begin
                if (m2p || bus.mem_gnt_i) begin
                    cmd_d.maddr = cmd_q.maddr + XLEN'(4);
                    cmd_d.cnt   = cmd_q.cnt - 1'b1;
                    paddr_d     = paddr_q + 1'b1;
                    state_d     = (cmd_q.cnt == DMA_CNT_W'(1)) ? IDLE : SRC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_src     = (state_q == SRC);
    assign in_dst     = (state_q == DST);
    assign m2p        = (cmd_q.dir == DIR_MEM2PIM);
    assign dma_busy_o = (state_q != IDLE);

    // Outputs decode only registered state, so they hold steady while waiting for grant
    assign bus.mem_read_o    = in_src && m2p;
    assign bus.mem_write_o   = in_dst && !m2p;
    assign bus.mem_req_o     = bus.mem_read_o || bus.mem_write_o;
    assign bus.mem_size_o    = bus.mem_req_o ? 4'b1111 : 4'b0000;
    assign bus.mem_addr_o    = (in_src || in_dst) ? cmd_q.maddr : '0;
    assign bus.mem_wr_data_o = bus.mem_write_o ? buf_q : '0;

    assign bus.pim_read_o    = in_src && !m2p;
    assign bus.pim_write_o   = in_dst && m2p;
    assign bus.pim_addr_o    = (in_src || in_dst) ? paddr_q : '0;
    assign bus.pim_wr_data_o = bus.pim_write_o ? buf_q : '0;
    assign bus.pim_sel_o     = dma_busy_o ? cmd_q.sel : 4'b0000;

endmodule

// File: tb/tb_dma_ctrl.sv
// tb/tb_dma_ctrl.sv - directed self-checking bench for dma_ctrl
module tb_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [2:0]  funct3;
    logic [3:0]  sel;
    logic [12:0] size;
    logic [31:0] addr;
    logic        busy;

    int total = 0;
    int bad   = 0;

    dma_ctrl_if #(.XLEN(32), .PIM_AW(11)) bus ();

    dma_ctrl #(.XLEN(32), .PIM_AW(11)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .dma_en_i       (en),
        .dma_funct3_i   (funct3),
        .dma_sel_pim_i  (sel),
        .dma_size_i     (size),
        .dma_mem_addr_i (addr),
        .dma_busy_o     (busy),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    // Memory returns {addr[15:0], C0DE}; PIM returns A5A5_0000 | word address
    logic [31:0] rd_q[$];
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [31:0] ws_q[$];
    logic [31:0] pa_q[$];
    logic [31:0] pd_q[$];
    int busy_n = 0;
    int req_n  = 0;
    int pim_n  = 0;

    always @(posedge clk) begin
        if (busy) busy_n <= busy_n + 1;
        if (bus.mem_req_o) req_n <= req_n + 1;
        if (bus.pim_read_o || bus.pim_write_o) pim_n <= pim_n + 1;
        if (bus.mem_req_o && bus.mem_gnt_i && bus.mem_read_o) begin
            rd_q.push_back(bus.mem_addr_o);
            bus.mem_rd_data_i <= {bus.mem_addr_o[15:0], 16'hC0DE};
        end
        if (bus.mem_req_o && bus.mem_gnt_i && bus.mem_write_o) begin
            wa_q.push_back(bus.mem_addr_o);
            wd_q.push_back(bus.mem_wr_data_o);
            ws_q.push_back({28'd0, bus.mem_size_o});
        end
        if (bus.pim_read_o)
            bus.pim_rd_data_i <= 32'hA5A5_0000 | {21'd0, bus.pim_addr_o};
        if (bus.pim_write_o) begin
            pa_q.push_back({21'd0, bus.pim_addr_o});
            pd_q.push_back(bus.pim_wr_data_o);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [3:0] s, input logic [12:0] sz,
                         input logic [31:0] a);
        @(negedge clk);
        en = 1'b1; funct3 = f; sel = s; size = sz; addr = a;
        @(negedge clk);
        en = 1'b0; funct3 = 3'd0; sel = 4'd0; size = 13'd0; addr = 32'd0;
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_req"},   {31'd0, bus.mem_req_o}, 32'd0);
        check({tag, "_rd"},    {31'd0, bus.mem_read_o}, 32'd0);
        check({tag, "_wr"},    {31'd0, bus.mem_write_o}, 32'd0);
        check({tag, "_msize"}, {28'd0, bus.mem_size_o}, 32'd0);
        check({tag, "_maddr"}, bus.mem_addr_o, 32'd0);
        check({tag, "_mwd"},   bus.mem_wr_data_o, 32'd0);
        check({tag, "_psel"},  {28'd0, bus.pim_sel_o}, 32'd0);
        check({tag, "_paddr"}, {21'd0, bus.pim_addr_o}, 32'd0);
        check({tag, "_pwd"},   bus.pim_wr_data_o, 32'd0);
        check({tag, "_prd"},   {31'd0, bus.pim_read_o}, 32'd0);
        check({tag, "_pwr"},   {31'd0, bus.pim_write_o}, 32'd0);
    endtask

    int rb, wb, pb, bb, qb, nb;
    logic [31:0] exp_ra[4];
    logic [31:0] exp_pd[4];

    initial begin
        rst_n = 1'b0; en = 1'b0; funct3 = 3'd0; sel = 4'd0; size = 13'd0; addr = 32'd0;
        bus.mem_gnt_i = 1'b1;
        bus.mem_rd_data_i = 32'd0;
        bus.pim_rd_data_i = 32'd0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst_n = 1'b1;

        // MEM2PIM, 4 words, grant always high
        exp_ra = '{32'h2000_0010, 32'h2000_0014, 32'h2000_0018, 32'h2000_001C};
        exp_pd = '{32'h0010_C0DE, 32'h0014_C0DE, 32'h0018_C0DE, 32'h001C_C0DE};
        rb = rd_q.size(); pb = pa_q.size(); wb = wa_q.size(); bb = busy_n;
        issue(3'b000, 4'b0010, 13'd16, 32'h2000_0010);
        check("m2p_busy_rise", {31'd0, busy}, 32'd1);
        check("m2p_sel", {28'd0, bus.pim_sel_o}, 32'h2);
        wait_idle(100);
        check("m2p_busy_cycles", busy_n - bb, 32'd12);
        check("m2p_nreads", rd_q.size() - rb, 32'd4);
        check("m2p_npim", pa_q.size() - pb, 32'd4);
        check("m2p_nmemwr", wa_q.size() - wb, 32'd0);
        for (int i = 0; i < 4; i++) begin
            if (rb + i < rd_q.size()) check($sformatf("m2p_raddr%0d", i), rd_q[rb+i], exp_ra[i]);
            if (pb + i < pa_q.size()) begin
                check($sformatf("m2p_paddr%0d", i), pa_q[pb+i], i);
                check($sformatf("m2p_pdata%0d", i), pd_q[pb+i], exp_pd[i]);
            end
        end
        check("m2p_sel_idle", {28'd0, bus.pim_sel_o}, 32'd0);

        // PIM2MEM, 2 words, misaligned address
        wb = wa_q.size(); bb = busy_n; rb = rd_q.size();
        issue(3'b001, 4'b0100, 13'd8, 32'h2000_0102);
        wait_idle(100);
        check("p2m_busy_cycles", busy_n - bb, 32'd6);
        check("p2m_nwr", wa_q.size() - wb, 32'd2);
        check("p2m_nrd", rd_q.size() - rb, 32'd0);
        if (wa_q.size() >= wb + 2) begin
            check("p2m_waddr0", wa_q[wb], 32'h2000_0100);
            check("p2m_wdata0", wd_q[wb], 32'hA5A5_0000);
            check("p2m_wsize0", ws_q[wb], 32'hF);
            check("p2m_waddr1", wa_q[wb+1], 32'h2000_0104);
            check("p2m_wdata1", wd_q[wb+1], 32'hA5A5_0001);
            check("p2m_wsize1", ws_q[wb+1], 32'hF);
        end

        // Grant withheld three cycles on a 1-word MEM2PIM
        bus.mem_gnt_i = 1'b0;
        bb = busy_n; pb = pa_q.size();
        issue(3'b000, 4'b0001, 13'd4, 32'h3000_0008);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_req%0d", i), {31'd0, bus.mem_req_o}, 32'd1);
            check($sformatf("stall_rd%0d", i), {31'd0, bus.mem_read_o}, 32'd1);
            check($sformatf("stall_addr%0d", i), bus.mem_addr_o, 32'h3000_0008);
            check($sformatf("stall_size%0d", i), {28'd0, bus.mem_size_o}, 32'hF);
            @(negedge clk);
        end
        bus.mem_gnt_i = 1'b1;
        wait_idle(100);
        check("stall_busy_cycles", busy_n - bb, 32'd6);
        check("stall_npim", pa_q.size() - pb, 32'd1);
        if (pa_q.size() > pb) check("stall_pdata", pd_q[pb], 32'h0008_C0DE);

        // Ignored commands: zero word count, illegal funct3
        bb = busy_n; qb = req_n; nb = pim_n;
        issue(3'b000, 4'b0001, 13'd3, 32'h2000_0000);
        repeat (4) @(negedge clk);
        issue(3'b010, 4'b0001, 13'd16, 32'h2000_0000);
        repeat (4) @(negedge clk);
        check("ign_busy", busy_n - bb, 32'd0);
        check("ign_req", req_n - qb, 32'd0);
        check("ign_pim", pim_n - nb, 32'd0);

        // Second strobe while busy is dropped
        bb = busy_n; rb = rd_q.size(); wb = wa_q.size(); pb = pa_q.size();
        issue(3'b000, 4'b1000, 13'd8, 32'h4000_0000);
        @(negedge clk);
        issue(3'b001, 4'b0001, 13'd16, 32'h5000_0000);
        wait_idle(100);
        repeat (3) @(negedge clk);
        check("dbl_busy_cycles", busy_n - bb, 32'd6);
        check("dbl_nrd", rd_q.size() - rb, 32'd2);
        check("dbl_nmemwr", wa_q.size() - wb, 32'd0);
        check("dbl_npim", pa_q.size() - pb, 32'd2);
        if (pa_q.size() >= pb + 2) begin
            check("dbl_pdata0", pd_q[pb], 32'h0000_C0DE);
            check("dbl_pdata1", pd_q[pb+1], 32'h0004_C0DE);
        end

        // Reset during the second word's CAP of a 4-word transfer
        issue(3'b000, 4'b0010, 13'd16, 32'h6000_0000);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_quiet("midrst");
        repeat (2) @(negedge clk);
        check_quiet("midrst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {31'd0, busy}, 32'd0);
        bb = busy_n; pb = pa_q.size();
        issue(3'b000, 4'b0001, 13'd4, 32'h7000_0004);
        wait_idle(100);
        check("post_rst_busy_cycles", busy_n - bb, 32'd3);
        check("post_rst_npim", pa_q.size() - pb, 32'd1);
        if (pa_q.size() > pb) begin
            check("post_rst_paddr", pa_q[pb], 32'd0);
            check("post_rst_pdata", pd_q[pb], 32'h0004_C0DE);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
